// File: rtl/pc_sequencer.sv
// Program-counter register stage: registers the PC mux output and adds halt, misaligned-fault trap and debug counters.
// Latency: pc_out follows next_pc one edge later; pc2_out is combinational from pc_out.
// Backpressure: stall or HALT holds the PC and counters; FAULT holds everything until clear_fault.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] FAULT_VECTOR = 16'h0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] next_pc,
    input  logic        jbp_enable,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        resume,
    input  logic        clear_fault,
    output logic [15:0] pc_out,
    output logic [15:0] pc2_out,
    output logic [1:0]  state,
    output logic        fault,
    output logic [15:0] fault_addr,
    output logic        fault_redirect,
    output logic [15:0] retired_count,
    output logic [7:0]  redirect_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10,
        ST_ILL   = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] faddr_q, faddr_d;
    logic        fredir_q, fredir_d;
    logic [15:0] retired_q, retired_d;
    logic [7:0]  redirect_q, redirect_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VECTOR;
            faddr_q    <= 16'h0000;
            fredir_q   <= 1'b0;
            retired_q  <= 16'h0000;
            redirect_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            faddr_q    <= faddr_d;
            fredir_q   <= fredir_d;
            retired_q  <= retired_d;
            redirect_q <= redirect_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        faddr_d    = faddr_q;
        fredir_d   = fredir_q;
        retired_d  = retired_q;
        redirect_d = redirect_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    state_d = ST_RUN;
                end else if (next_pc[0]) begin
                    state_d  = ST_FAULT;
                    faddr_d  = next_pc;
                    fredir_d = jbp_enable;
                end else begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 16'd1;
                    if (jbp_enable && (redirect_q != 8'hFF)) begin
                        redirect_d = redirect_q + 8'd1;
                    end
                end
            end
            ST_HALT: begin
                // A held halt_req wins over resume so the core cannot slip out mid-request.
                if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    state_d = ST_RUN;
                    pc_d    = FAULT_VECTOR;
                end
            end
            default: begin
                state_d  = ST_FAULT;
                faddr_d  = pc_q;
                fredir_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_out         = pc_q;
        pc2_out        = pc_q + 16'd2;
        state          = state_q;
        fault          = (state_q == ST_FAULT);
        fault_addr     = faddr_q;
        fault_redirect = fredir_q;
        retired_count  = retired_q;
        redirect_count = redirect_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, corner sequences and a randomized run against a reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] next_pc;
    logic        jbp_enable, stall, halt_req, resume, clear_fault;
    logic [15:0] pc_out, pc2_out, fault_addr, retired_count;
    logic [1:0]  state;
    logic        fault, fault_redirect;
    logic [7:0]  redirect_count;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: mode 0 run, 1 halt, 2 fault
    int          m_mode;
    logic [15:0] m_pc, m_faddr, m_ret;
    logic        m_fred;
    int          m_redir;

    typedef struct {
        logic [15:0] np;
        logic        jbp, stl, hlt, res, clr;
        logic [15:0] exp_pc;
        logic [1:0]  exp_st;
        logic [15:0] exp_ret;
        logic [7:0]  exp_red;
    } vec_t;

    vec_t tbl[16];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .next_pc        (next_pc),
        .jbp_enable     (jbp_enable),
        .stall          (stall),
        .halt_req       (halt_req),
        .resume         (resume),
        .clear_fault    (clear_fault),
        .pc_out         (pc_out),
        .pc2_out        (pc2_out),
        .state          (state),
        .fault          (fault),
        .fault_addr     (fault_addr),
        .fault_redirect (fault_redirect),
        .retired_count  (retired_count),
        .redirect_count (redirect_count)
    );

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 16'h0000;
        m_faddr = 16'h0000;
        m_fred  = 1'b0;
        m_ret   = 16'h0000;
        m_redir = 0;
    endtask

    task automatic model_edge();
        if (m_mode == 0) begin
            if (halt_req) m_mode = 1;
            else if (stall) m_mode = 0;
            else if (next_pc % 2 == 1) begin
                m_mode  = 2;
                m_faddr = next_pc;
                m_fred  = jbp_enable;
            end else begin
                m_pc  = next_pc;
                m_ret = m_ret + 16'd1;
                if (jbp_enable) m_redir = (m_redir >= 255) ? 255 : m_redir + 1;
            end
        end else if (m_mode == 1) begin
            if (resume && !halt_req) m_mode = 0;
        end else begin
            if (clear_fault) begin
                m_mode = 0;
                m_pc   = 16'h0010;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] exp_pc2;
        logic [1:0]  exp_st;
        exp_pc2 = m_pc + 16'd2;
        exp_st  = 2'(m_mode);
        cmp({tag, ".pc"}, pc_out, m_pc);
        cmp({tag, ".pc2"}, pc2_out, exp_pc2);
        cmp({tag, ".state"}, {14'b0, state}, {14'b0, exp_st});
        cmp({tag, ".fault"}, {15'b0, fault}, (m_mode == 2) ? 16'd1 : 16'd0);
        cmp({tag, ".faddr"}, fault_addr, m_faddr);
        cmp({tag, ".fredir"}, {15'b0, fault_redirect}, {15'b0, m_fred});
        cmp({tag, ".retired"}, retired_count, m_ret);
        cmp({tag, ".redirects"}, {8'b0, redirect_count}, 16'(m_redir));
    endtask

    // inputs driven at the falling edge, outputs checked at the following falling edge
    task automatic step(input logic [15:0] np, input logic j, input logic s,
                        input logic h, input logic r, input logic c, input string tag);
        next_pc     = np;
        jbp_enable  = j;
        stall       = s;
        halt_req    = h;
        resume      = r;
        clear_fault = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        //         np        j  s  h  r  c   pc        st     ret      red
        tbl[0]  = '{16'h0002, 0, 0, 0, 0, 0, 16'h0002, 2'b00, 16'd1, 8'd0};
        tbl[1]  = '{16'h0004, 0, 0, 0, 0, 0, 16'h0004, 2'b00, 16'd2, 8'd0};
        tbl[2]  = '{16'h0006, 0, 0, 0, 0, 0, 16'h0006, 2'b00, 16'd3, 8'd0};
        tbl[3]  = '{16'h0008, 0, 0, 0, 0, 0, 16'h0008, 2'b00, 16'd4, 8'd0};
        tbl[4]  = '{16'h1234, 1, 0, 0, 0, 0, 16'h1234, 2'b00, 16'd5, 8'd1};
        tbl[5]  = '{16'h5678, 0, 1, 0, 0, 0, 16'h1234, 2'b00, 16'd5, 8'd1};
        tbl[6]  = '{16'h1236, 1, 1, 0, 0, 0, 16'h1234, 2'b00, 16'd5, 8'd1};
        tbl[7]  = '{16'hFFFF, 1, 0, 0, 0, 0, 16'h1234, 2'b10, 16'd5, 8'd1};
        tbl[8]  = '{16'h0040, 0, 1, 1, 1, 0, 16'h1234, 2'b10, 16'd5, 8'd1};
        tbl[9]  = '{16'h0040, 0, 0, 0, 0, 1, 16'h0010, 2'b00, 16'd5, 8'd1};
        tbl[10] = '{16'h0003, 0, 1, 1, 0, 0, 16'h0010, 2'b01, 16'd5, 8'd1};
        tbl[11] = '{16'h0020, 0, 0, 0, 1, 0, 16'h0010, 2'b00, 16'd5, 8'd1};
        tbl[12] = '{16'h0020, 1, 0, 0, 0, 0, 16'h0020, 2'b00, 16'd6, 8'd2};
        tbl[13] = '{16'h0030, 0, 0, 1, 0, 0, 16'h0020, 2'b01, 16'd6, 8'd2};
        tbl[14] = '{16'h0030, 0, 0, 1, 1, 0, 16'h0020, 2'b01, 16'd6, 8'd2};
        tbl[15] = '{16'h0030, 0, 1, 0, 1, 0, 16'h0020, 2'b00, 16'd6, 8'd2};

        rst_n = 1'b0;
        {next_pc, jbp_enable, stall, halt_req, resume, clear_fault} = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_model("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].np, tbl[i].jbp, tbl[i].stl, tbl[i].hlt, tbl[i].res, tbl[i].clr, $sformatf("row%0d", i));
            cmp($sformatf("tbl%0d.pc", i), pc_out, tbl[i].exp_pc);
            cmp($sformatf("tbl%0d.pc2", i), pc2_out, tbl[i].exp_pc + 16'd2);
            cmp($sformatf("tbl%0d.state", i), {14'b0, state}, {14'b0, tbl[i].exp_st});
            cmp($sformatf("tbl%0d.ret", i), retired_count, tbl[i].exp_ret);
            cmp($sformatf("tbl%0d.red", i), {8'b0, redirect_count}, {8'b0, tbl[i].exp_red});
        end
        cmp("fault_addr_kept", fault_addr, 16'hFFFF);
        cmp("fault_redir_kept", {15'b0, fault_redirect}, 16'd1);

        // PC+2 wraparound
        step(16'hFFFE, 0, 0, 0, 0, 0, "wrap0");
        cmp("wrap_pc2", pc2_out, 16'h0000);
        step(pc2_out, 0, 0, 0, 0, 0, "wrap1");
        cmp("wrap_pc", pc_out, 16'h0000);

        // redirect counter saturation
        for (int i = 0; i < 300; i++) step(16'(16'h0100 + 2 * i), 1, 0, 0, 0, 0, "sat");
        cmp("sat_red", {8'b0, redirect_count}, 16'h00FF);
        step(16'h0200, 1, 0, 0, 0, 0, "sat_hold");
        cmp("sat_red_hold", {8'b0, redirect_count}, 16'h00FF);

        // async reset while halted with nonzero counters
        step(16'h0300, 0, 0, 1, 0, 0, "pre_rst");
        cmp("pre_rst_state", {14'b0, state}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        cmp("arst_pc", pc_out, 16'h0000);
        cmp("arst_state", {14'b0, state}, 16'd0);
        cmp("arst_ret", retired_count, 16'h0000);
        cmp("arst_red", {8'b0, redirect_count}, 16'h0000);
        cmp("arst_faddr", fault_addr, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h0002, 0, 0, 0, 0, 0, "post_rst");
        cmp("post_rst_pc", pc_out, 16'h0002);

        // randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] np;
            np = 16'($urandom);
            if ($urandom_range(0, 7) != 0) np[0] = 1'b0;
            step(np, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
